// File: rtl/spi_pkt_pkg.sv
// Shared definitions for the sensor-packet SPI link: packet geometry, FSM
// state encoding and the field-to-packet packing helper.
package spi_pkt_pkg;

  localparam int PACKET_SIZE = 16;
  localparam logic [7:0] HEADER_BYTE = 8'hAA;
  localparam int PACKET_BITS = 128;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETUP    = 3'd1,
    ST_SHIFT_HI = 3'd2,
    ST_SHIFT_LO = 3'd3,
    ST_GAP      = 3'd4
  } spi_state_e;

  // Byte 0 is the header, then six big-endian int16 fields, flags, two pad bytes.
  function automatic logic [PACKET_BITS-1:0] pack_sensor_packet(
    input logic [15:0] roll,
    input logic [15:0] pitch,
    input logic [15:0] yaw,
    input logic [15:0] gyro_x,
    input logic [15:0] gyro_y,
    input logic [15:0] gyro_z,
    input logic [7:0]  flags
  );
    return {HEADER_BYTE, roll, pitch, yaw, gyro_x, gyro_y, gyro_z, flags, 16'h0000};
  endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// SCK half-period timer: counts CLK_DIV cycles per phase while enabled and
// flags the end of a low phase (rise_tick) or a high phase (fall_tick).
module spi_sck_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic sck_level,
  output logic rise_tick,
  output logic fall_tick
);

  localparam int CW = $clog2(CLK_DIV + 1);

  logic [CW-1:0] cnt;
  logic          wrap;

  assign wrap      = en && (cnt == CW'(CLK_DIV - 1));
  assign rise_tick = wrap && !sck_level;
  assign fall_tick = wrap && sck_level;

  always_ff @(posedge clk) begin
    if (!rst_n || !en) begin
      cnt <= '0;
    end else if (wrap) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/sensor_packet_spi_tx.sv
// SPI mode 0 master that frames one 16-byte sensor packet per start request
// and shifts it out MSB-first under an active-low chip select.
module sensor_packet_spi_tx
  import spi_pkt_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] roll,
  input  logic [15:0] pitch,
  input  logic [15:0] yaw,
  input  logic [15:0] gyro_x,
  input  logic [15:0] gyro_y,
  input  logic [15:0] gyro_z,
  input  logic [7:0]  flags,
  output logic        busy,
  output logic        done,
  output logic        cs_n,
  output logic        sck,
  output logic        sdo,
  output logic [2:0]  fsm_state
);

  localparam logic [2:0] IDLE     = ST_IDLE;
  localparam logic [2:0] SETUP    = ST_SETUP;
  localparam logic [2:0] SHIFT_HI = ST_SHIFT_HI;
  localparam logic [2:0] SHIFT_LO = ST_SHIFT_LO;
  localparam logic [2:0] GAP      = ST_GAP;
  localparam int GW = $clog2(GAP_CYCLES + 1);

  logic [2:0]             state;
  logic [PACKET_BITS-1:0] shreg;
  logic [PACKET_BITS-1:0] packed_fields;
  logic [6:0]             bit_cnt;
  logic [GW-1:0]          gap_cnt;
  logic                   sck_en;
  logic                   rise_tick;
  logic                   fall_tick;

  assign packed_fields = pack_sensor_packet(roll, pitch, yaw, gyro_x, gyro_y, gyro_z, flags);
  assign sck_en        = (state == SETUP) || (state == SHIFT_HI) || (state == SHIFT_LO);
  assign fsm_state     = state;

  spi_sck_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_sck_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (sck_en),
    .sck_level(sck),
    .rise_tick(rise_tick),
    .fall_tick(fall_tick)
  );

  // bit_cnt names the bit the receiver samples in the current/next high phase.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      gap_cnt <= '0;
      cs_n    <= 1'b1;
      sck     <= 1'b0;
      sdo     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shreg   <= packed_fields;
            sdo     <= packed_fields[PACKET_BITS-1];
            cs_n    <= 1'b0;
            busy    <= 1'b1;
            bit_cnt <= 7'd127;
            state   <= SETUP;
          end
        end
        SETUP: begin
          if (rise_tick) begin
            sck   <= 1'b1;
            state <= SHIFT_HI;
          end
        end
        SHIFT_HI: begin
          if (fall_tick) begin
            sck   <= 1'b0;
            shreg <= {shreg[PACKET_BITS-2:0], 1'b0};
            sdo   <= shreg[PACKET_BITS-2];
            state <= SHIFT_LO;
          end
        end
        SHIFT_LO: begin
          if (rise_tick) begin
            if (bit_cnt == 7'd0) begin
              cs_n    <= 1'b1;
              sdo     <= 1'b0;
              done    <= 1'b1;
              gap_cnt <= '0;
              state   <= GAP;
            end else begin
              bit_cnt <= bit_cnt - 7'd1;
              sck     <= 1'b1;
              state   <= SHIFT_HI;
            end
          end
        end
        GAP: begin
          if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/sensor_packet_spi_tx.md
# sensor_packet_spi_tx

SPI Mode 0 master transmitter that frames one 16-byte sensor packet per request and shifts it out MSB-first under an active-low chip select. It is the sending end of the team's sensor-packet SPI link. It lets the FPGA drive a downstream SPI slave, or loop back into the team's packet receiver for bring-up, using the same packet format the Arduino produces. The block packs orientation, gyro and flag fields into the packet itself, so callers supply values, not bytes.

## Interface
- `CLK_DIV`, default 4: SCK half-period in `clk` cycles; legal range ≥1.
- `GAP_CYCLES`, default 8: minimum `clk` cycles with `cs_n` high between packets; legal range ≥1.
- `clk` in 1: system clock; the only clock in the block.
- `rst_n` in 1: reset, synchronous and active-low.
- `start` in 1: request to send one packet; sampled only in IDLE.
- `roll`, `pitch`, `yaw` in 16 each: Euler angles, int16 scaled by 100.
- `gyro_x`, `gyro_y`, `gyro_z` in 16 each: angular rates, int16 scaled by 2000.
- `flags` in 8: status flags.
- `busy` out 1: high from the cycle after `start` is accepted through the end of GAP.
- `done` out 1: one-cycle pulse in the cycle `cs_n` returns high.
- `cs_n` out 1: chip select, active low.
- `sck` out 1: SPI clock; idles low (CPOL=0).
- `sdo` out 1: MOSI data.

## Operation
- Packet byte order:
  - Byte 0: 0xAA.
  - Bytes 1–12: roll, pitch, yaw, gyro_x, gyro_y, gyro_z, each as MSB byte then LSB byte.
  - Byte 13: flags.
  - Bytes 14–15: 0x00.
- Field inputs are captured into a 128-bit shift register in the cycle `start` is accepted. Later input changes do not affect the packet in flight.
- FSM states: IDLE → SETUP → SHIFT_HI ↔ SHIFT_LO → GAP → IDLE.
  - IDLE: `cs_n`=1, `sck`=0, `sdo`=0. If `start`=1, capture fields and go to SETUP.
  - SETUP: lasts `CLK_DIV` cycles. `cs_n`=0, `sck`=0, `sdo` = packet bit 127 (the first bit, =1).
  - SHIFT_HI: lasts `CLK_DIV` cycles. `sck`=1, `sdo` is held stable. The receiver samples on the SCK rising edge.
  - SHIFT_LO: lasts `CLK_DIV` cycles. `sck`=0. On entry, `sdo` advances to the next bit (changes on the falling edge). After bit 0's low phase, go to GAP; otherwise return to SHIFT_HI.
  - GAP: lasts `GAP_CYCLES` cycles with `cs_n`=1. `done` pulses on the first GAP cycle. Go to IDLE at the end.
- Bit counter runs 7 bits, from 127 down to 0. The half-period counter is `$clog2(CLK_DIV+1)` bits wide and wraps to 0 at every phase change.
- `start` while `busy` is ignored, not queued.
- `start` held high continuously sends back-to-back packets, separated by exactly `GAP_CYCLES`+1 `cs_n`-high cycles (GAP plus the IDLE acceptance cycle).

## Timing
- All outputs are registered, so `sck`, `cs_n` and `sdo` are glitch-free.
- Reset values: `cs_n`=1, `sck`=0, `sdo`=0, `busy`=0, `done`=0, FSM in IDLE, shift register cleared.
- Cycle T: `start` is sampled. At T+1: `cs_n`=0, `busy`=1, `sdo`=1.
- First SCK rising edge is at T+1+`CLK_DIV`.
- `cs_n` stays low for `CLK_DIV`×257 cycles (1028 at the default). `cs_n` rises `CLK_DIV` cycles after the last SCK falling edge, which gives hold time.
- Exactly 128 SCK rising edges occur per packet. No SCK edge occurs while `cs_n` is high.
- Reset asserted mid-packet: on the next edge, `cs_n`=1 and `sck`=0, with no `done` pulse. The partial packet is abandoned.
- `rst_n` low and `start` high in the same cycle: reset wins.

## Structure
- Shared package `spi_pkt_pkg` holds:
  - `PACKET_SIZE`=16
  - `HEADER_BYTE`=8'hAA
  - `PACKET_BITS`=128
  - the FSM state enum
  - a `pack_sensor_packet` function (fields → 128-bit vector), reused by benches and future blocks.
- One natural sub-module: `spi_sck_gen`. It is the half-period counter and issues `rise_tick`/`fall_tick` when enabled. The FSM and shift register stay in the top module.

## Test plan
- After reset, with no `start`: `cs_n`=1, `sck`=0, `sdo`=0, `busy`=0 held for 100 cycles.
- Send roll=0x1234, pitch=0xFEDC, yaw=0x0001, gyro_x=0x8000, gyro_y=0x7FFF, gyro_z=0x00FF, flags=0x5A. Sample `sdo` on SCK rising edges. Expect bytes AA 12 34 FE DC 00 01 80 00 7F FF 00 FF 5A 00 00, and exactly 128 rises.
- `CLK_DIV`=4: `cs_n` low for exactly 1028 cycles; `done` is a single pulse on the `cs_n` rising cycle; `sdo` changes only while `sck`=0.
- Pulse `start` again mid-packet, and change the fields mid-packet. Expect only one packet, containing the originally captured values.
- Hold `start` high for 3 packets. Expect 3 identical frames, each separated by 9 `cs_n`-high cycles (`GAP_CYCLES`=8).
- Deassert `rst_n` at bit 60. Expect the next cycle to show `cs_n`=1, `sck`=0, no `done`. A following `start` then sends a full, correct packet.
